// File: rtl/unscr_pkg.sv
// unscr_pkg - shared definitions for the unscrambler/packer datapath.
//
// Holds the datapath widths, the bit packer FSM state type and a helper
// that clamps oversized chunk lengths. Imported by bit_packer and
// packer_align.
package unscr_pkg;

    localparam int WORD_W  = 32;
    localparam int CHUNK_W = 64;
    localparam int ACC_W   = 128;
    localparam int CNT_W   = 8;
    localparam int SIZE_W  = 7;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Chunk lengths above the chunk width are treated as a full chunk.
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] size);
        return (size > SIZE_W'(CHUNK_W)) ? SIZE_W'(CHUNK_W) : size;
    endfunction

endpackage

// File: rtl/packer_align.sv
// packer_align - combinational barrel shifter for the bit packer.
//
// Places the valid bits of a chunk (chunk[size-1:0], chunk[size-1] first)
// into an MSB-aligned accumulator-wide vector starting at bit position
// 'offset' counted from the MSB. All other bits are zero.
//
// Ports:
//   chunk  - raw chunk, valid bits right-aligned
//   size   - number of valid bits, already clamped to 0..CHUNK_W
//   offset - number of accumulator bits already occupied (0..CHUNK_W)
//   placed - chunk positioned for OR-ing into the accumulator
module packer_align
    import unscr_pkg::*;
(
    input  logic [CHUNK_W-1:0] chunk,
    input  logic [SIZE_W-1:0]  size,
    input  logic [CNT_W-1:0]   offset,
    output logic [ACC_W-1:0]   placed
);

    logic [CHUNK_W-1:0] left;

    // Left-justify the chunk first; shifting by CHUNK_W - size also drops
    // any garbage above the valid bits, and a zero size yields all zeros.
    always_comb begin
        left   = chunk << (SIZE_W'(CHUNK_W) - size);
        placed = {left, {(ACC_W - CHUNK_W){1'b0}}} >> offset;
    end

endmodule

// File: rtl/bit_packer.sv
// bit_packer - packs variable-length chunks (0..64 bits) into 32-bit words.
//
// Bits collect in a 128-bit MSB-aligned accumulator. Whenever at least 32
// bits are present and the downstream FIFO is not full, the top word is
// emitted. A flush pulse pads the trailing partial word with zeros, emits
// it, and then reports completion with a one-cycle flush_done pulse.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   clk_en       - clock enable, all state holds while low
//   pack_in      - chunk data, valid bits pack_in[size-1:0], MSB first
//   pack_size    - chunk length 0..64 (65..127 treated as 64)
//   pack_wr      - chunk valid
//   pack_ready   - packer can accept a chunk this cycle
//   flush        - pad and emit the pending partial word
//   out_full     - downstream word FIFO full
//   out_word     - packed word, MSB is the earliest bit
//   out_wr       - one-cycle write strobe for out_word
//   flush_done   - one-cycle pulse when a flush completes
//   word_cnt     - emitted word count (only with BIT_PACKER_STATS_EN)
//
// Optional feature: define BIT_PACKER_STATS_EN to add the word_cnt port.
module bit_packer
    import unscr_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic [CHUNK_W-1:0]  pack_in,
    input  logic [SIZE_W-1:0]   pack_size,
    input  logic                pack_wr,
    output logic                pack_ready,
    input  logic                flush,
    input  logic                out_full,
`ifdef BIT_PACKER_STATS_EN
    output logic [WORD_W-1:0]   word_cnt,
`endif
    output logic [WORD_W-1:0]   out_word,
    output logic                out_wr,
    output logic                flush_done
);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  placed;
    logic [ACC_W-1:0]  merged;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [SIZE_W-1:0] size_eff;
    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              emit_full;
    logic              emit_part;
    logic              out_wr_q;
    logic              flush_done_q;

    packer_align u_align (
        .chunk  (pack_in),
        .size   (size_eff),
        .offset (cnt),
        .placed (placed)
    );

    // Accept/emit decisions and next accumulator contents. A chunk never
    // overlaps the top word while a full word is being emitted (cnt >= 32
    // then), so the chunk is merged first and the result shifted after.
    always_comb begin
        size_eff   = clamp_size(pack_size);
        pack_ready = (cnt <= CNT_W'(CHUNK_W)) && (state == RUN);
        accept     = pack_wr && pack_ready && clk_en;
        emit_full  = (cnt >= CNT_W'(WORD_W)) && !out_full;
        emit_part  = (state == FLUSH) && (cnt != '0) &&
                     (cnt < CNT_W'(WORD_W)) && !out_full;
        merged     = accept ? (acc | placed) : acc;
        acc_next   = merged;
        cnt_next   = accept ? (cnt + {1'b0, size_eff}) : cnt;
        if (emit_full) begin
            acc_next = merged << WORD_W;
            cnt_next = cnt_next - CNT_W'(WORD_W);
        end else if (emit_part) begin
            acc_next = '0;
            cnt_next = '0;
        end
    end

    // Flush sequencing: stay in FLUSH until the accumulator is drained,
    // then spend one cycle in DONE to signal completion.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush) state_next = FLUSH;
            FLUSH:   if (cnt == '0) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Datapath and FSM registers; everything freezes while clk_en is low.
    // The partial-word path relies on bits below cnt always being zero,
    // which holds because shifts insert zeros and a partial emit clears acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            state        <= RUN;
            out_word     <= '0;
            out_wr_q     <= 1'b0;
            flush_done_q <= 1'b0;
        end else if (clk_en) begin
            acc          <= acc_next;
            cnt          <= cnt_next;
            state        <= state_next;
            out_wr_q     <= emit_full || emit_part;
            flush_done_q <= (state == FLUSH) && (cnt == '0);
            if (emit_full || emit_part) begin
                out_word <= acc[ACC_W-1 -: WORD_W];
            end
        end
    end

    assign out_wr     = out_wr_q && clk_en;
    assign flush_done = flush_done_q && clk_en;

`ifdef BIT_PACKER_STATS_EN
    // Word statistics, restarted at the end of every flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (flush_done) begin
            word_cnt <= '0;
        end else if (out_wr) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end
`endif

endmodule
